// File: rtl/mc_ctrl_fsm.sv
// Multicycle main-control FSM for the taylor MIPS core, with a memory-ready watchdog.
// Optional ADDI support is built when MC_ADDI_EN is defined.
module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [3:0] state,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
`ifdef MC_ADDI_EN
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
`endif
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'h08;
`endif

    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT - 1);

    state_t          cur;
    logic [TO_W-1:0] wd;
    logic            fault_r;

    // Watchdog defaults to clear; only a memory state that is still waiting
    // overrides it with an increment, so every entry starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur     <= S_FETCH;
            wd      <= '0;
            fault_r <= 1'b0;
        end else begin
            wd <= '0;
            case (cur)
                S_FETCH: begin
                    if (mem_ready) begin
                        cur <= S_DECODE;
                    end else if (wd == WD_LIMIT) begin
                        cur     <= S_FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     cur <= S_EXEC;
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_BEQ:       cur <= S_BRANCH;
                        OP_J:         cur <= S_JUMP;
`ifdef MC_ADDI_EN
                        OP_ADDI:      cur <= S_ADDIEX;
`endif
                        default: begin
                            cur     <= S_FAULT;
                            fault_r <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (mem_ready) begin
                        cur <= S_MEMWB;
                    end else if (wd == WD_LIMIT) begin
                        cur     <= S_FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_MEMWB:  cur <= S_FETCH;
                S_MEMWR: begin
                    if (mem_ready) begin
                        cur <= S_FETCH;
                    end else if (wd == WD_LIMIT) begin
                        cur     <= S_FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_EXEC:   cur <= S_ALUWB;
                S_ALUWB:  cur <= S_FETCH;
                S_BRANCH: cur <= S_FETCH;
                S_JUMP:   cur <= S_FETCH;
`ifdef MC_ADDI_EN
                S_ADDIEX: cur <= S_ADDIWB;
                S_ADDIWB: cur <= S_FETCH;
`endif
                S_FAULT:  cur <= S_FAULT;
                default: begin
                    cur     <= S_FAULT;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

    // Decoded from the registered state; only the fetch-cycle IR/PC strobes
    // follow mem_ready combinationally so the IR loads in the completing cycle.
    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state = cur;
    assign fault = fault_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm; ADDI expectations follow MC_ADDI_EN.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_write, pc_write_cond, fault;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    logic [16:0] act;

    int checks   = 0;
    int failures = 0;

    mc_ctrl_fsm #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    // {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //  alu_src_b, alu_op, pc_src, pc_write, pc_write_cond, fault}
    assign act = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, pc_write, pc_write_cond, fault};

    localparam logic [16:0] W_F      = 17'b0_1_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [16:0] W_FR     = 17'b0_1_0_1_0_0_0_0_01_00_00_1_0_0;
    localparam logic [16:0] W_DEC    = 17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [16:0] W_MEMADR = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [16:0] W_MEMRD  = 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] W_MEMWB  = 17'b0_0_0_0_0_1_1_0_00_00_00_0_0_0;
    localparam logic [16:0] W_MEMWR  = 17'b1_0_1_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] W_EXEC   = 17'b0_0_0_0_0_0_0_1_00_10_00_0_0_0;
    localparam logic [16:0] W_ALUWB  = 17'b0_0_0_0_1_0_1_0_00_00_00_0_0_0;
    localparam logic [16:0] W_BR     = 17'b0_0_0_0_0_0_0_1_00_01_01_0_1_0;
    localparam logic [16:0] W_J      = 17'b0_0_0_0_0_0_0_0_00_00_10_1_0_0;
    localparam logic [16:0] W_FLT    = 17'b0_0_0_0_0_0_0_0_00_00_00_0_0_1;
`ifdef MC_ADDI_EN
    localparam logic [16:0] W_ADDIEX = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [16:0] W_ADDIWB = 17'b0_0_0_0_0_0_1_0_00_00_00_0_0_0;
`endif

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] w;
    } vec_t;

    vec_t vecs [24];

    task automatic drive(input logic [5:0] op, input logic mr);
        opcode    = op;
        mem_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp_st, input logic [16:0] exp_w);
        checks++;
        if (state !== exp_st || act !== exp_w) begin
            failures++;
            $display("FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     name, state, act, exp_st, exp_w);
        end
    endtask

    // Pulses reset between clock edges and leaves the DUT idle in FETCH.
    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{6'h00, 1'b1, 4'd0, W_FR};
        vecs[1]  = '{6'h00, 1'b1, 4'd1, W_DEC};
        vecs[2]  = '{6'h00, 1'b0, 4'd6, W_EXEC};
        vecs[3]  = '{6'h00, 1'b0, 4'd7, W_ALUWB};
        vecs[4]  = '{6'h23, 1'b0, 4'd0, W_F};
        vecs[5]  = '{6'h23, 1'b1, 4'd0, W_FR};
        vecs[6]  = '{6'h23, 1'b1, 4'd1, W_DEC};
        vecs[7]  = '{6'h23, 1'b1, 4'd2, W_MEMADR};
        vecs[8]  = '{6'h23, 1'b0, 4'd3, W_MEMRD};
        vecs[9]  = '{6'h23, 1'b0, 4'd3, W_MEMRD};
        vecs[10] = '{6'h23, 1'b0, 4'd3, W_MEMRD};
        vecs[11] = '{6'h23, 1'b1, 4'd3, W_MEMRD};
        vecs[12] = '{6'h23, 1'b1, 4'd4, W_MEMWB};
        vecs[13] = '{6'h2B, 1'b1, 4'd0, W_FR};
        vecs[14] = '{6'h2B, 1'b1, 4'd1, W_DEC};
        vecs[15] = '{6'h2B, 1'b1, 4'd2, W_MEMADR};
        vecs[16] = '{6'h2B, 1'b1, 4'd5, W_MEMWR};
        vecs[17] = '{6'h04, 1'b1, 4'd0, W_FR};
        vecs[18] = '{6'h04, 1'b1, 4'd1, W_DEC};
        vecs[19] = '{6'h04, 1'b1, 4'd8, W_BR};
        vecs[20] = '{6'h02, 1'b1, 4'd0, W_FR};
        vecs[21] = '{6'h02, 1'b1, 4'd1, W_DEC};
        vecs[22] = '{6'h02, 1'b1, 4'd9, W_J};
        vecs[23] = '{6'h00, 1'b0, 4'd0, W_F};

        // Reset state
        #12;
        chk("reset", 4'd0, W_F);
        rst = 1'b1;

        // Instruction sequences, one vector per cycle
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].op, vecs[i].mr);
            #2;
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].w);
            tick();
        end

        // mem_ready arriving on the watchdog limit cycle wins
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            drive(6'h00, 1'b0);
            #2;
            chk($sformatf("limit_wait%0d", i), 4'd0, W_F);
            tick();
        end
        drive(6'h00, 1'b1);
        #2;
        chk("limit_ready", 4'd0, W_FR);
        tick();
        chk("limit_decode", 4'd1, W_DEC);

        // FETCH timeout: 16 idle cycles trap, IR never loaded
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            drive(6'h00, 1'b0);
            #2;
            chk($sformatf("to_fetch%0d", i), 4'd0, W_F);
            tick();
        end
        chk("to_fetch_fault", 4'd15, W_FLT);
        drive(6'h00, 1'b1);
        tick();
        chk("fault_absorbing", 4'd15, W_FLT);
        drive(6'h00, 1'b0);
        pulse_reset();
        chk("fault_cleared", 4'd0, W_F);

        // MEMRD timeout
        drive(6'h23, 1'b1);
        tick();
        tick();
        tick();
        drive(6'h23, 1'b0);
        #2;
        chk("to_memrd_enter", 4'd3, W_MEMRD);
        for (int i = 0; i < 16; i++) tick();
        chk("to_memrd_fault", 4'd15, W_FLT);

        // Illegal opcode
        pulse_reset();
        drive(6'h3F, 1'b1);
        tick();
        tick();
        chk("illegal_fault", 4'd15, W_FLT);

        // ADDI
        pulse_reset();
        drive(6'h08, 1'b1);
        tick();
        tick();
`ifdef MC_ADDI_EN
        chk("addi_ex", 4'd10, W_ADDIEX);
        tick();
        chk("addi_wb", 4'd11, W_ADDIWB);
        tick();
        chk("addi_fetch", 4'd0, W_FR);
`else
        chk("addi_fault", 4'd15, W_FLT);
`endif

        // Asynchronous reset in the middle of MEMWR
        pulse_reset();
        drive(6'h2B, 1'b1);
        tick();
        tick();
        tick();
        drive(6'h2B, 1'b0);
        #2;
        chk("memwr_before_rst", 4'd5, W_MEMWR);
        rst = 1'b0;
        #1;
        chk("memwr_async_rst", 4'd0, W_F);
        #1;
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
